// File: rtl/ppu_mem_pkg.sv
// ----------------------------------------------------------------------------
// ppu_mem_pkg
//   Shared types and constants for the PPU memory arbiter slice.
//   Contents: PPU mode enum, CPU address map constants, default OAM DMA
//   length, CPU/DMA FSM state enums, CPU region enum and address decoder.
// ----------------------------------------------------------------------------
package ppu_mem_pkg;

  typedef enum logic [1:0] {
    HBLANK   = 2'd0,
    VBLANK   = 2'd1,
    OAM_SCAN = 2'd2,
    XFER     = 2'd3
  } ppu_mode_t;

  localparam logic [15:0] VRAM_BASE    = 16'h8000;
  localparam logic [15:0] VRAM_END     = 16'h9FFF;
  localparam logic [15:0] OAM_BASE     = 16'hFE00;
  localparam logic [15:0] OAM_END      = 16'hFE9F;
  localparam logic [15:0] DMA_REG_ADDR = 16'hFF46;

  localparam int DMA_LEN_DEFAULT = 160;

  typedef enum logic {
    C_IDLE,
    C_ACK
  } cpu_state_t;

  typedef enum logic [1:0] {
    D_IDLE,
    D_RD,
    D_WR,
    D_WAIT
  } dma_state_t;

  // CPU-visible target of an access; RGN_NONE doubles as "return 8'hFF".
  typedef enum logic [1:0] {
    RGN_NONE,
    RGN_VRAM,
    RGN_OAM,
    RGN_DMA
  } region_t;

  function automatic region_t decode_region(input logic [15:0] a);
    if (a >= VRAM_BASE && a <= VRAM_END)     return RGN_VRAM;
    else if (a >= OAM_BASE && a <= OAM_END)  return RGN_OAM;
    else if (a == DMA_REG_ADDR)              return RGN_DMA;
    else                                     return RGN_NONE;
  endfunction

endpackage

// File: rtl/oam_dma_engine.sv
// ----------------------------------------------------------------------------
// oam_dma_engine
//   OAM DMA sequencer: copies DMA_LEN bytes from {src_page, i} to OAM[i],
//   spending DMA_CYCLES_PER_BYTE clocks per byte (read, write, wait).
//   A start pulse restarts from byte 0 even while a transfer is running.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   start, src_page   begin/restart a transfer from page {src_page,8'h00}
//   busy              transfer in progress
//   src_a, src_rd     source read request to the external fabric
//   src_din           source data, valid the cycle after src_rd
//   oam_a/oam_din/oam_wr  OAM write port (only meaningful while busy)
// ----------------------------------------------------------------------------
module oam_dma_engine
  import ppu_mem_pkg::*;
#(
  parameter int DMA_CYCLES_PER_BYTE = 4,
  parameter int DMA_LEN             = DMA_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [7:0]  src_page,
  output logic        busy,
  output logic [15:0] src_a,
  output logic        src_rd,
  input  logic [7:0]  src_din,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_wr
);

  localparam logic [7:0] LAST_IDX  = 8'(DMA_LEN - 1);
  // D_WAIT counts down to zero, so it is loaded with (idle cycles - 1).
  localparam logic [3:0] WAIT_INIT = 4'(DMA_CYCLES_PER_BYTE - 3);

  dma_state_t state;
  logic [7:0] idx;
  logic [7:0] page;
  logic [3:0] wait_cnt;
  logic       wr_q;
  logic       step;

  // step: the current byte's time slot is used up; move to the next byte.
  // With two cycles per byte there is no D_WAIT, so D_WR ends the slot.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves step
    // unassigned; otherwise synthesis infers a latch.
    step = 1'b0;
    case (state)
      D_WR:    step = (DMA_CYCLES_PER_BYTE == 2);
      D_WAIT:  step = (wait_cnt == 4'd0);
      default: step = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= D_IDLE;
      idx      <= 8'h00;
      page     <= 8'h00;
      wait_cnt <= 4'd0;
      busy     <= 1'b0;
      src_a    <= 16'h0000;
      src_rd   <= 1'b0;
      wr_q     <= 1'b0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every
      // flop samples pre-edge values regardless of statement order.
      src_rd <= 1'b0;
      wr_q   <= 1'b0;
      if (start) begin
        // Restart wins over whatever the engine was doing this cycle.
        state  <= D_RD;
        idx    <= 8'h00;
        page   <= src_page;
        busy   <= 1'b1;
        src_a  <= {src_page, 8'h00};
        src_rd <= 1'b1;
      end else if (step) begin
        if (idx == LAST_IDX) begin
          state <= D_IDLE;
          busy  <= 1'b0;
        end else begin
          idx    <= idx + 8'd1;
          state  <= D_RD;
          src_a  <= {page, idx + 8'd1};
          src_rd <= 1'b1;
        end
      end else begin
        case (state)
          D_RD: begin
            state <= D_WR;
            wr_q  <= 1'b1;
          end
          D_WR: begin
            state    <= D_WAIT;
            wait_cnt <= WAIT_INIT;
          end
          D_WAIT:  wait_cnt <= wait_cnt - 4'd1;
          default: ;
        endcase
      end
    end
  end

  // Source data arrives combinationally in D_WR and goes straight to OAM.
  assign oam_a   = idx;
  assign oam_din = src_din;
  assign oam_wr  = wr_q;

endmodule

// File: rtl/ppu_mem_arbiter.sv
// ----------------------------------------------------------------------------
// ppu_mem_arbiter
//   Shares the single-port VRAM and OAM BRAMs between the PPU, the CPU bus
//   and the OAM DMA engine, enforcing PPU mode 2/3 locking, and implements
//   the 0xFF46 DMA register.
// Build option:
//   CPU_STALL_EN  when defined, a locked CPU VRAM/OAM access waits (no ack)
//                 until the lock clears instead of completing as a dropped
//                 write / 8'hFF read.
// Ports:
//   clk, rst_n                    4 MHz clock, asynchronous active-low reset
//   lcd_on, ppu_mode              PPU state used for locking
//   ppu_vram_a/dout, ppu_oam_a/dout  PPU read ports (data one cycle later)
//   cpu_req/we/a/din/dout/ack     CPU access handshake (ack is a 1-cycle pulse)
//   dma_busy, dma_src_a/rd/din    OAM DMA status and source fabric bus
//   vram_a/din/wr/dout            VRAM BRAM port
//   oam_a/din/wr/dout             OAM BRAM port
// ----------------------------------------------------------------------------
module ppu_mem_arbiter
  import ppu_mem_pkg::*;
#(
  parameter int DMA_CYCLES_PER_BYTE = 4,
  parameter int DMA_LEN             = DMA_LEN_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_on,
  input  logic [1:0]  ppu_mode,
  input  logic [12:0] ppu_vram_a,
  output logic [7:0]  ppu_vram_dout,
  input  logic [7:0]  ppu_oam_a,
  output logic [7:0]  ppu_oam_dout,
  input  logic        cpu_req,
  input  logic        cpu_we,
  input  logic [15:0] cpu_a,
  input  logic [7:0]  cpu_din,
  output logic [7:0]  cpu_dout,
  output logic        cpu_ack,
  output logic        dma_busy,
  output logic [15:0] dma_src_a,
  output logic        dma_src_rd,
  input  logic [7:0]  dma_src_din,
  output logic [12:0] vram_a,
  output logic [7:0]  vram_din,
  output logic        vram_wr,
  input  logic [7:0]  vram_dout,
  output logic [7:0]  oam_a,
  output logic [7:0]  oam_din,
  output logic        oam_wr,
  input  logic [7:0]  oam_dout
);

  cpu_state_t cstate;
  region_t    region;
  region_t    rd_src;
  ppu_mode_t  mode;
  logic [7:0] dma_reg;
  logic       vram_lock;
  logic       oam_lock;
  logic       locked;
  logic       accept;
  logic       grant;
  logic       cpu_vram_go;
  logic       cpu_oam_go;
  logic       dma_start;
  logic [7:0] dma_oam_a;
  logic [7:0] dma_oam_din;
  logic       dma_oam_wr;

  assign mode   = ppu_mode_t'(ppu_mode);
  assign region = decode_region(cpu_a);

  assign vram_lock = lcd_on && (mode == XFER);
  assign oam_lock  = dma_busy || (lcd_on && (mode == OAM_SCAN || mode == XFER));
  assign locked    = (region == RGN_VRAM && vram_lock) ||
                     (region == RGN_OAM  && oam_lock);

`ifdef CPU_STALL_EN
  // Locked VRAM/OAM requests are held off; everything else is taken at once.
  assign accept = (cstate == C_IDLE) && cpu_req && !locked;
`else
  assign accept = (cstate == C_IDLE) && cpu_req;
`endif

  // grant: the accepted access actually reaches a BRAM or the DMA register.
  assign grant       = accept && !locked;
  assign cpu_vram_go = grant && (region == RGN_VRAM);
  assign cpu_oam_go  = grant && (region == RGN_OAM);
  assign dma_start   = grant && (region == RGN_DMA) && cpu_we;

  // VRAM port: CPU only when it was granted (never under vram_lock).
  assign vram_a        = cpu_vram_go ? cpu_a[12:0] : ppu_vram_a;
  assign vram_din      = cpu_din;
  assign vram_wr       = cpu_vram_go && cpu_we;
  assign ppu_vram_dout = vram_dout;

  // OAM port: DMA > CPU (granted, so not locked) > PPU. oam_lock already
  // covers dma_busy, so cpu_oam_go is never set while DMA owns the port.
  assign oam_a   = dma_busy ? dma_oam_a   : (cpu_oam_go ? cpu_a[7:0] : ppu_oam_a);
  assign oam_din = dma_busy ? dma_oam_din : cpu_din;
  assign oam_wr  = dma_busy ? dma_oam_wr  : (cpu_oam_go && cpu_we);
  assign ppu_oam_dout = dma_busy ? 8'hFF : oam_dout;

  // BRAM read data lands in T+1, so the read source is registered in T and
  // the data is steered combinationally during the ack cycle.
  always_comb begin
    case (rd_src)
      RGN_VRAM: cpu_dout = vram_dout;
      RGN_OAM:  cpu_dout = oam_dout;
      RGN_DMA:  cpu_dout = dma_reg;
      default:  cpu_dout = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cstate  <= C_IDLE;
      cpu_ack <= 1'b0;
      rd_src  <= RGN_NONE;
      dma_reg <= 8'h00;
    end else begin
      case (cstate)
        C_IDLE: begin
          if (accept) begin
            cstate  <= C_ACK;
            cpu_ack <= 1'b1;
            rd_src  <= (locked || cpu_we) ? RGN_NONE : region;
            if (dma_start) dma_reg <= cpu_din;
          end
        end
        default: begin
          // cpu_req is deliberately ignored here: one access per 2 cycles.
          cstate  <= C_IDLE;
          cpu_ack <= 1'b0;
          rd_src  <= RGN_NONE;
        end
      endcase
    end
  end

  oam_dma_engine #(
    .DMA_CYCLES_PER_BYTE (DMA_CYCLES_PER_BYTE),
    .DMA_LEN             (DMA_LEN)
  ) u_dma (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (dma_start),
    .src_page (cpu_din),
    .busy     (dma_busy),
    .src_a    (dma_src_a),
    .src_rd   (dma_src_rd),
    .src_din  (dma_src_din),
    .oam_a    (dma_oam_a),
    .oam_din  (dma_oam_din),
    .oam_wr   (dma_oam_wr)
  );

endmodule
